// File: rtl/arbiter_pkg.sv
// Shared types for the three-port DMA bus arbiter: FSM states, port indices
// and the registered bus request payload.
package arbiter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MASK_W    = 4;
  localparam int unsigned NUM_PORTS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  typedef logic [1:0] arb_port_t;

  localparam arb_port_t PORT_A = 2'd0;
  localparam arb_port_t PORT_B = 2'd1;
  localparam arb_port_t PORT_C = 2'd2;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } bus_req_t;

endpackage

// File: rtl/arb_pick3.sv
// Combinational three-way grant picker. ARBITER_ROUND_ROBIN_EN selects
// round-robin starting after the last grant; otherwise fixed priority a > b > c.
module arb_pick3
  import arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] request,
  input  arb_port_t            last,
  output arb_port_t            grant,
  output logic                 valid
);

`ifdef ARBITER_ROUND_ROBIN_EN
  arb_port_t first, second, third;

  // Search order rotates so the port after the last grant is tried first.
  always_comb begin
    first  = PORT_A;
    second = PORT_B;
    third  = PORT_C;
    case (last)
      PORT_A: begin first = PORT_B; second = PORT_C; third = PORT_A; end
      PORT_B: begin first = PORT_C; second = PORT_A; third = PORT_B; end
      default: begin first = PORT_A; second = PORT_B; third = PORT_C; end
    endcase
  end

  always_comb begin
    grant = PORT_A;
    valid = |request;
    if (request[first])       grant = first;
    else if (request[second]) grant = second;
    else if (request[third])  grant = third;
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant = PORT_A;
    valid = |request;
    if (request[0])      grant = PORT_A;
    else if (request[1]) grant = PORT_B;
    else if (request[2]) grant = PORT_C;
  end
`endif

endmodule

// File: rtl/triple_port_arbiter.sv
// Merges three DMA request/ready masters onto one registered bus master port,
// one transaction at a time. Define ARBITER_ROUND_ROBIN_EN for round-robin grants.
module triple_port_arbiter
  import arbiter_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_pa_request,
  input  logic              i_pa_rw,
  input  logic [ADDR_W-1:0] i_pa_address,
  input  logic [DATA_W-1:0] i_pa_wdata,
  input  logic [MASK_W-1:0] i_pa_wmask,
  output logic              o_pa_ready,
  output logic [DATA_W-1:0] o_pa_rdata,
  input  logic              i_pb_request,
  input  logic              i_pb_rw,
  input  logic [ADDR_W-1:0] i_pb_address,
  input  logic [DATA_W-1:0] i_pb_wdata,
  input  logic [MASK_W-1:0] i_pb_wmask,
  output logic              o_pb_ready,
  output logic [DATA_W-1:0] o_pb_rdata,
  input  logic              i_pc_request,
  input  logic              i_pc_rw,
  input  logic [ADDR_W-1:0] i_pc_address,
  input  logic [DATA_W-1:0] i_pc_wdata,
  input  logic [MASK_W-1:0] i_pc_wmask,
  output logic              o_pc_ready,
  output logic [DATA_W-1:0] o_pc_rdata,
  output logic              o_bus_request,
  output logic              o_bus_rw,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [MASK_W-1:0] o_bus_wmask,
  input  logic              i_bus_ready,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  arb_state_t           state_q, state_d;
  bus_req_t             bus_q, bus_d;
  logic                 bus_request_q, bus_request_d;
  logic [NUM_PORTS-1:0] ready_q, ready_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  arb_port_t            grant_q, grant_d;
  arb_port_t            last;
  arb_port_t            pick_grant;
  logic                 pick_valid;
  logic [NUM_PORTS-1:0] req_vec;
  bus_req_t             pick_req;

  assign req_vec = {i_pc_request, i_pb_request, i_pa_request};

`ifdef ARBITER_ROUND_ROBIN_EN
  arb_port_t last_q, last_d;
  assign last = last_q;
`else
  assign last = PORT_C;
`endif

  arb_pick3 u_pick (
    .request (req_vec),
    .last    (last),
    .grant   (pick_grant),
    .valid   (pick_valid)
  );

  // Payload of the port the picker selected.
  always_comb begin
    case (pick_grant)
      PORT_B:  pick_req = '{rw: i_pb_rw, address: i_pb_address, wdata: i_pb_wdata, wmask: i_pb_wmask};
      PORT_C:  pick_req = '{rw: i_pc_rw, address: i_pc_address, wdata: i_pc_wdata, wmask: i_pc_wmask};
      default: pick_req = '{rw: i_pa_rw, address: i_pa_address, wdata: i_pa_wdata, wmask: i_pa_wmask};
    endcase
  end

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d       = state_q;
    bus_d         = bus_q;
    bus_request_d = bus_request_q;
    ready_d       = '0;
    rdata_d       = rdata_q;
    grant_d       = grant_q;
`ifdef ARBITER_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          bus_d         = pick_req;
          bus_request_d = 1'b1;
          grant_d       = pick_grant;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (i_bus_ready) begin
          rdata_d          = i_bus_rdata;
          bus_request_d    = 1'b0;
          ready_d[grant_q] = 1'b1;
          state_d          = ACK;
        end
      end
      ACK: begin
`ifdef ARBITER_ROUND_ROBIN_EN
        last_d  = grant_q;
`endif
        state_d = IDLE;
      end
      default: begin
        bus_request_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      bus_q         <= '0;
      bus_request_q <= 1'b0;
      ready_q       <= '0;
      rdata_q       <= '0;
      grant_q       <= PORT_A;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_q        <= PORT_C;
`endif
    end else begin
      state_q       <= state_d;
      bus_q         <= bus_d;
      bus_request_q <= bus_request_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      grant_q       <= grant_d;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  assign o_bus_request = bus_request_q;
  assign o_bus_rw      = bus_q.rw;
  assign o_bus_address = bus_q.address;
  assign o_bus_wdata   = bus_q.wdata;
  assign o_bus_wmask   = bus_q.wmask;
  assign o_pa_ready    = ready_q[0];
  assign o_pb_ready    = ready_q[1];
  assign o_pc_ready    = ready_q[2];
  assign o_pa_rdata    = rdata_q;
  assign o_pb_rdata    = rdata_q;
  assign o_pc_rdata    = rdata_q;

endmodule

// File: tb/tb_triple_port_arbiter.sv
// Directed-vector bench for triple_port_arbiter; expectations follow
// ARBITER_ROUND_ROBIN_EN when it is defined for the build.
module tb_triple_port_arbiter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_pa_request, i_pa_rw, i_pb_request, i_pb_rw, i_pc_request, i_pc_rw;
  logic [31:0] i_pa_address, i_pa_wdata, i_pb_address, i_pb_wdata, i_pc_address, i_pc_wdata;
  logic [3:0]  i_pa_wmask, i_pb_wmask, i_pc_wmask;
  logic        o_pa_ready, o_pb_ready, o_pc_ready;
  logic [31:0] o_pa_rdata, o_pb_rdata, o_pc_rdata;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  triple_port_arbiter dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_pa_request(i_pa_request), .i_pa_rw(i_pa_rw), .i_pa_address(i_pa_address),
    .i_pa_wdata(i_pa_wdata), .i_pa_wmask(i_pa_wmask), .o_pa_ready(o_pa_ready), .o_pa_rdata(o_pa_rdata),
    .i_pb_request(i_pb_request), .i_pb_rw(i_pb_rw), .i_pb_address(i_pb_address),
    .i_pb_wdata(i_pb_wdata), .i_pb_wmask(i_pb_wmask), .o_pb_ready(o_pb_ready), .o_pb_rdata(o_pb_rdata),
    .i_pc_request(i_pc_request), .i_pc_rw(i_pc_rw), .i_pc_address(i_pc_address),
    .i_pc_wdata(i_pc_wdata), .i_pc_wmask(i_pc_wmask), .o_pc_ready(o_pc_ready), .o_pc_rdata(o_pc_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic step();
    @(negedge i_clock);
  endtask

  function automatic logic [31:0] readies();
    return {29'd0, o_pc_ready, o_pb_ready, o_pa_ready};
  endfunction

  initial begin
    logic [31:0] exp_addr [4];
    logic [31:0] exp_rdy  [4];
    bit          seen;

    i_reset = 1'b1;
    {i_pa_request, i_pa_rw, i_pb_request, i_pb_rw, i_pc_request, i_pc_rw} = '0;
    i_pa_address = 32'hA0; i_pb_address = 32'hB0; i_pc_address = 32'hC0;
    i_pa_wdata = '0; i_pb_wdata = '0; i_pc_wdata = '0;
    i_pa_wmask = '0; i_pb_wmask = '0; i_pc_wmask = '0;
    i_bus_ready = 1'b0; i_bus_rdata = '0;
    step(); step();
    check("rst_bus_request", {31'd0, o_bus_request}, 32'd0);
    check("rst_readies", readies(), 32'd0);
    check("rst_rdata", o_pa_rdata, 32'd0);
    check("rst_address", o_bus_address, 32'd0);
    i_reset = 1'b0;

    // Single read on port a, bus ready in the third BUSY cycle.
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h0000_0040;
    step();
    check("rd_bus_request", {31'd0, o_bus_request}, 32'd1);
    check("rd_address", o_bus_address, 32'h0000_0040);
    check("rd_rw", {31'd0, o_bus_rw}, 32'd0);
    step();
    step();
    check("rd_hold_request", {31'd0, o_bus_request}, 32'd1);
    check("rd_early_ready", readies(), 32'd0);
    i_bus_ready = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    step();
    check("rd_ready", readies(), 32'd1);
    check("rd_rdata", o_pa_rdata, 32'hDEAD_BEEF);
    check("rd_bus_request_low", {31'd0, o_bus_request}, 32'd0);
    i_pa_request = 1'b0; i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
    step();
    check("rd_ready_pulse", readies(), 32'd0);

    // Write on port b; fields must hold even if the requester changes them.
    i_pb_request = 1'b1; i_pb_rw = 1'b1; i_pb_address = 32'h0000_1000;
    i_pb_wdata = 32'h1234_5678; i_pb_wmask = 4'b1111;
    step();
    check("wr_bus_request", {31'd0, o_bus_request}, 32'd1);
    check("wr_rw", {31'd0, o_bus_rw}, 32'd1);
    check("wr_address", o_bus_address, 32'h0000_1000);
    check("wr_wdata", o_bus_wdata, 32'h1234_5678);
    check("wr_wmask", {28'd0, o_bus_wmask}, 32'hF);
    i_pb_address = 32'hFFFF_0000; i_pb_wdata = 32'h0; i_pb_wmask = 4'b0000; i_pb_rw = 1'b0;
    step();
    check("wr_hold_address", o_bus_address, 32'h0000_1000);
    check("wr_hold_wdata", o_bus_wdata, 32'h1234_5678);
    check("wr_hold_wmask", {28'd0, o_bus_wmask}, 32'hF);
    check("wr_hold_rw", {31'd0, o_bus_rw}, 32'd1);
    i_bus_ready = 1'b1; i_bus_rdata = 32'h0000_CAFE;
    step();
    check("wr_ready", readies(), 32'd2);
    check("wr_rdata", o_pb_rdata, 32'h0000_CAFE);
    i_pb_request = 1'b0; i_bus_ready = 1'b0;
    step();
    check("wr_ready_pulse", readies(), 32'd0);

    // Stray bus ready in IDLE: no pulse, no request, rdata held.
    i_bus_ready = 1'b1; i_bus_rdata = 32'h5555_5555;
    step();
    check("stray_readies", readies(), 32'd0);
    check("stray_bus_request", {31'd0, o_bus_request}, 32'd0);
    check("stray_rdata", o_pc_rdata, 32'h0000_CAFE);
    i_bus_ready = 1'b0;
    step();
    check("stray_readies_2", readies(), 32'd0);

    // Reset during BUSY aborts the transaction.
    i_pc_request = 1'b1; i_pc_rw = 1'b1; i_pc_address = 32'h0000_00C0;
    step();
    check("rb_bus_request", {31'd0, o_bus_request}, 32'd1);
    check("rb_address", o_bus_address, 32'h0000_00C0);
    i_reset = 1'b1;
    step();
    check("rb_bus_request_low", {31'd0, o_bus_request}, 32'd0);
    check("rb_readies", readies(), 32'd0);
    check("rb_rdata", o_pa_rdata, 32'd0);
    i_reset = 1'b0;

    // All three ports requesting continuously.
    i_pa_rw = 1'b0; i_pb_rw = 1'b0; i_pc_rw = 1'b0;
    i_pa_address = 32'hA0; i_pb_address = 32'hB0; i_pc_address = 32'hC0;
    i_pa_request = 1'b1; i_pb_request = 1'b1; i_pc_request = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_addr = '{32'hA0, 32'hB0, 32'hC0, 32'hA0};
    exp_rdy  = '{32'd1, 32'd2, 32'd4, 32'd1};
`else
    exp_addr = '{32'hA0, 32'hA0, 32'hA0, 32'hA0};
    exp_rdy  = '{32'd1, 32'd1, 32'd1, 32'd1};
`endif
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
        step();
        seen = o_bus_request;
      end
      check($sformatf("rr_grant_seen_%0d", g), {31'd0, seen}, 32'd1);
      check($sformatf("rr_address_%0d", g), o_bus_address, exp_addr[g]);
      i_bus_ready = 1'b1; i_bus_rdata = 32'h100 + 32'(g);
      step();
      check($sformatf("rr_ready_%0d", g), readies(), exp_rdy[g]);
      check($sformatf("rr_rdata_%0d", g), o_pa_rdata, 32'h100 + 32'(g));
      i_bus_ready = 1'b0;
      step();
      check($sformatf("rr_idle_gap_%0d", g), {31'd0, o_bus_request}, 32'd0);
    end
    i_pa_request = 1'b0; i_pb_request = 1'b0; i_pc_request = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/triple_port_arbiter.md
# triple_port_arbiter

Three-requester bus arbiter that merges the bus masters of the three DMA channels onto the single DMA bus master port. Each requester uses the same request/ready handshake as the system bus. One transaction is in flight at a time. Grants are round-robin, or fixed priority when the feature macro is absent. Bus signals are registered, so the downstream bus sees glitch-free, stable address, data and mask for the whole transaction.

## Interface
- No parameters. Address and data widths are fixed at 32 bits; the write mask is 4 bits.
- i_clock  in  1  single clock; all logic is on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_pX_request  in  1  port X (X = a, b, c) transaction request; held high until o_pX_ready.
- i_pX_rw  in  1  port X direction: 1 = write, 0 = read.
- i_pX_address  in  32  port X byte address.
- i_pX_wdata  in  32  port X write data.
- i_pX_wmask  in  4  port X byte-lane write mask.
- o_pX_ready  out  1  one-cycle completion pulse to port X.
- o_pX_rdata  out  32  read data; valid only while o_pX_ready = 1.
- o_bus_request  out  1  downstream request.
- o_bus_rw  out  1  downstream direction.
- o_bus_address  out  32  downstream address.
- o_bus_wdata  out  32  downstream write data.
- o_bus_wmask  out  4  downstream write mask.
- i_bus_ready  in  1  downstream completion; single-cycle pulse.
- i_bus_rdata  in  32  downstream read data; valid with i_bus_ready.

## Operation
- State machine with three states:
  - IDLE: no transaction in flight.
  - BUSY: granted port's transaction is on the bus.
  - ACK: completion pulse is being returned to the granted port.
- IDLE
  - When any i_pX_request is high, select one port, then:
    - latch that port's rw, address, wdata and wmask into the bus registers;
    - set o_bus_request = 1;
    - record the grant index;
    - go to BUSY.
  - With no request, stay in IDLE.
- BUSY
  - The bus registers hold constant; requester inputs are ignored.
  - On i_bus_ready = 1: capture i_bus_rdata into the shared rdata register, clear o_bus_request, set the granted port's o_pX_ready, go to ACK.
- ACK
  - Clear o_pX_ready, update the priority pointer to the granted index, go to IDLE.
- Requester rule: the requester drops i_pX_request on the edge where it samples o_pX_ready = 1. As a result, the arbiter in IDLE never re-grants a completed request.
- o_pa_rdata, o_pb_rdata and o_pc_rdata are all driven from the single shared rdata register.
- i_bus_ready while not in BUSY is ignored.
- A request dropped by a requester while it is granted (a protocol violation) does not abort the bus transaction. The transaction completes and the ready pulse is still issued.
- Reset, at any time including mid-transaction:
  - state = IDLE;
  - all outputs = 0, including o_bus_request and every o_pX_ready;
  - rdata register = 0;
  - priority pointer = port c, so port a is first in round-robin order.

## Timing
- A request first seen high at edge N gives o_bus_request = 1 from cycle N+1.
- i_bus_ready high in cycle M gives o_pX_ready = 1 in cycle M+1 and o_bus_request = 0 in cycle M+1.
- Minimum request-to-ready latency is 2 cycles, reached when the bus is ready in the first cycle.
- Back-to-back transactions leave at least 1 IDLE cycle between successive bus requests.
- Output registers are updated only on grant (bus fields) and on ready (rdata), and hold otherwise.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined:
  - On each grant, the search starts at the port after the last granted one, in cyclic order a→b→c→a.
  - Any continuously requesting port is served within 3 grants.
- Undefined: fixed priority a > b > c. The priority pointer is not implemented.

## Structure
- Shared package `arbiter_pkg`:
  - state enum `arb_state_t` (IDLE, BUSY, ACK);
  - 2-bit port index type `arb_port_t` with constants PORT_A = 0, PORT_B = 1, PORT_C = 2.
- Sub-module `arb_pick3`, purely combinational:
  - inputs: 3-bit request vector and last-granted index;
  - outputs: grant index and grant-valid;
  - `ifdef` selects round-robin or fixed-priority logic.

## Test plan
- Single read on port a: request at cycle 0, bus ready in cycle 3 with rdata 0xDEADBEEF → o_pa_ready high in cycle 4 only, o_pa_rdata = 0xDEADBEEF, o_bus_request low in cycle 4.
- Write on port b: address 0x00001000, wdata 0x12345678, wmask 4'b1111 → bus fields equal those values and stay stable for the whole BUSY interval; o_bus_rw = 1.
- All three ports requesting continuously with round-robin enabled → grant order a, b, c, a. Without the macro → a, a, a, with b and c starved.
- Stray i_bus_ready in IDLE → no o_pX_ready pulse and no state change.
- i_reset asserted in BUSY, before bus ready → next cycle: o_bus_request = 0, all o_pX_ready = 0, IDLE. The first grant after reset goes to a when all ports request.
